// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional feature macro: ARB_TIMEOUT_EN (grantee stall timeout).
package uart_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int N_REQ_MAX    = 8;
  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD_RATE    = 115_200;
  localparam int CLKS_PER_BIT = 434;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Rotated priority encoder: the search starts at ptr and wraps, returning the
// first set request as one-hot plus its index.
module rr_priority_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the requests from ptr upward; the first hit wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                        = 1'b1;
        onehot[(int'(ptr) + k) % N] = 1'b1;
        idx                        = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet arbiter in front of a UART transmitter: one requester owns the
// byte stream until its last byte, chosen round-robin. One-entry output
// register decouples the grantee from tx_ready.
// Optional feature macro: ARB_TIMEOUT_EN (drop a grantee that stalls for
// TIMEOUT_CYCLES cycles, pulse timeout_pulse).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ*8-1:0] req_data,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout_pulse
);

  localparam int IDX_W = idx_width(N_REQ);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             out_free;
  logic             accept;
  logic [7:0]       own_data;
  logic             own_valid;
  logic             own_last;
  logic             pkt_done;
  logic             timeout_hit;

  rr_priority_picker #(.N(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Output register can take a byte when empty or being drained this cycle.
  assign out_free = !tx_valid || tx_ready;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign req_ready[i] = (state == GRANT) && grant[i] && out_free;
  end

  // Select the owner's byte and flags through the one-hot grant.
  always_comb begin
    own_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) own_data = own_data | req_data[i*8 +: 8];
  end

  assign own_valid = |(req_valid & grant);
  assign own_last  = |(req_last & grant);
  assign accept    = |(req_valid & req_ready);
  assign pkt_done  = accept && own_last;
  assign busy      = (state == GRANT) || tx_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt;

  // Fires in the stall cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state == GRANT) && !own_valid &&
                       (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive idle cycles of the grantee; restart per grant/byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;
      if (state == IDLE || accept || timeout_hit)
        stall_cnt <= '0;
      else if (!own_valid)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // Without the stall timeout a grant lasts until the last byte.
  assign timeout_hit   = 1'b0;
  assign timeout_pulse = 1'b0;

  // The limit only matters with the timeout; sink it so it reads as used.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: claim on any request, release on last byte or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = GRANT;
      GRANT:   if (pkt_done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and round-robin pointer; pointer moves past each new owner so a
  // timed-out owner is already skipped on the next arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else if (state == IDLE && pick_any) begin
      grant  <= pick_oh;
      rr_ptr <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end else if (state == GRANT && (pkt_done || timeout_hit)) begin
      grant  <= '0;
    end
  end

  // One-entry output register toward the UART.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (accept) begin
      tx_data  <= own_data;
      tx_valid <= 1'b1;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, meaning the number of packet requesters (legal 1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the grantee stall limit in clk cycles (used only with ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single system clock (50 MHz).
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_data  input  N_REQ*8  byte from each requester; requester i uses bits [i*8 +: 8].
REQ-006 SHALL have ports req_valid and req_last  input  N_REQ  byte-valid and last-byte-of-packet flags per requester.
REQ-007 SHALL have port req_ready  output  N_REQ  byte-accept per requester.
REQ-008 SHALL have ports tx_data  output  8  and tx_valid  output  1, driving the UART transmitter's data and valid inputs.
REQ-009 SHALL have port tx_ready  input  1  UART transmitter ready.
REQ-010 SHALL have ports grant  output  N_REQ  one-hot current owner, busy  output  1, and timeout_pulse  output  1.

Function
REQ-011 SHALL implement states IDLE and GRANT.
REQ-012 SHALL move from IDLE to GRANT, when any req_valid is high, at the clock edge ending that cycle.
REQ-013 SHALL select the new owner round-robin, starting at the index after the last owner (wrapping N_REQ-1 to 0), and SHALL hold grant one-hot throughout GRANT.
REQ-014 SHALL drive req_ready[g] = (state==GRANT) && grant[g] && (!tx_valid || tx_ready); req_ready SHALL be 0 for every other requester.
REQ-015 SHALL, for each accepted byte (req_valid[g] && req_ready[g]), register it into tx_data and drive tx_valid high in the next cycle.
REQ-016 SHALL clear tx_valid after a cycle with tx_valid && tx_ready when no new byte is accepted in that cycle.
REQ-017 SHALL hold tx_data stable while tx_valid && !tx_ready.
REQ-018 SHALL give a minimum latency of 2 cycles from req_valid first seen in IDLE (cycle N) to tx_valid (cycle N+2).
REQ-019 SHALL, when a byte is accepted with req_last=1, return to IDLE next cycle and clear grant; the last byte stays in the output register until consumed.
REQ-020 SHALL never interleave bytes of two packets; a new owner's first byte loads only once the output register is free.
REQ-021 SHALL sustain back-to-back bytes: with tx_ready held 1, one byte is transferred per cycle.
REQ-022 SHALL drive busy = (state==GRANT) || tx_valid.
REQ-023 SHALL give a single-requester system (N_REQ=1) IDLE/GRANT cycling with identical timing.

Reset
REQ-024 SHALL, on rst at a clock edge, set state=IDLE, grant=0, tx_valid=0, tx_data=8'h00, round-robin pointer=0 (requester 0 first), stall counter=0, and timeout_pulse=0.
REQ-025 SHALL have rst take priority over every other event; rst mid-packet SHALL discard the held byte and the remainder of the packet.

Configuration
REQ-026 SHALL, with ARB_TIMEOUT_EN defined, count consecutive GRANT cycles with req_valid[g]=0, clear the count on any accepted byte, and reset it on entering GRANT.
REQ-027 SHALL, when that count reaches TIMEOUT_CYCLES, pulse timeout_pulse for 1 cycle, clear grant, and go to IDLE with the pointer advanced past the stalled owner.
REQ-028 SHALL, without ARB_TIMEOUT_EN, omit the counter logic, tie timeout_pulse to 0, and hold a grant indefinitely until req_last.

Structure
REQ-029 SHALL place the state enum type, the N_REQ_MAX=8 constant, and the UART baud constants (CLKS_PER_BIT=434) in shared package uart_arb_pkg.
REQ-030 SHALL implement owner selection in one sub-module, rr_priority_picker (rotated priority encoder: request vector + pointer -> one-hot + index).

Verification
REQ-031 SHALL cover: req0 sends 8'h7B, 8'h22, 8'h0A (last), tx_ready=1 -> tx_data sequence 7B, 22, 0A on consecutive cycles, first tx_valid at N+2, grant=0 after the last byte.
REQ-032 SHALL cover: req0 and req1 both valid in the first cycle after reset -> req0's whole packet, then req1's, with no interleaving.
REQ-033 SHALL cover: req0 and req1 continuously offering 3-byte packets -> grant sequence 01, 10, 01, 10.
REQ-034 SHALL cover: tx_ready=0 for 10 cycles mid-packet -> tx_data held, req_ready=0, no byte lost or duplicated.
REQ-035 SHALL cover: rst asserted during the 2nd byte -> next cycle grant=0, tx_valid=0, tx_data=00, busy=0.
REQ-036 SHALL cover: ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, req0 drops valid after 2 bytes while req1 is pending -> timeout_pulse after 16 stalled cycles, then grant=10.
